// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus of the fetch stage
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: single-outstanding imem fetch, instruction register, redirects
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                instr_ack,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                fault,
    output logic [31:0]         fault_pc,
    output logic [31:0]         fetch_count
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc_q, pc_n;
    logic        kill, kill_n;
    logic [31:0] fault_pc_q, fault_pc_n;
    logic [31:0] count_q, count_n;
    logic        accept;
    logic        misaligned;

    assign accept     = (state == REQ) && imem.imem_ready;
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            kill       <= 1'b0;
            fault_pc_q <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            instr_q    <= instr_n;
            pc_q       <= pc_n;
            kill       <= kill_n;
            fault_pc_q <= fault_pc_n;
            count_q    <= count_n;
        end
    end

    // fetch_pc advances to the next word when a response is captured, so in HOLD
    // it already names the follow-on fetch and a redirect simply overwrites it.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        instr_n    = instr_q;
        pc_n       = pc_q;
        kill_n     = kill;
        fault_pc_n = fault_pc_q;
        count_n    = count_q;
        if (state != FAULT && misaligned) begin
            state_n    = FAULT;
            fault_pc_n = redirect_pc;
        end else begin
            case (state)
                IDLE: begin
                    state_n = REQ;
                    if (redirect) fetch_pc_n = redirect_pc;
                end
                REQ: begin
                    if (accept) state_n = WAIT;
                    if (redirect) begin
                        fetch_pc_n = redirect_pc;
                        if (accept) kill_n = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill || redirect) begin
                            kill_n  = 1'b0;
                            state_n = REQ;
                            if (redirect) fetch_pc_n = redirect_pc;
                        end else begin
                            instr_n    = imem.imem_rdata;
                            pc_n       = fetch_pc;
                            fetch_pc_n = fetch_pc + 32'd4;
                            count_n    = count_q + 32'd1;
                            state_n    = HOLD;
                        end
                    end else if (redirect) begin
                        fetch_pc_n = redirect_pc;
                        kill_n     = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) fetch_pc_n = redirect_pc;
                    if (instr_ack) state_n = REQ;
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = fetch_pc;
    assign instruction    = instr_q;
    assign instr_valid    = (state == HOLD);
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign fault          = (state == FAULT);
    assign fault_pc       = fault_pc_q;
    assign fetch_count    = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction, pc, pc_plus4, fault_pc, fetch_count;
    logic        instr_valid, fault;
    logic        instr_ack = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .imem(bus.master),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .instr_ack(instr_ack),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready, rvalid, ack, redir;
        logic [31:0] rdata, rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ins, pcv;
        logic        flt;
        logic [31:0] fpc, cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ready, logic rvalid, logic [31:0] rdata, logic ack,
                                logic redir, logic [31:0] rpc, logic req, logic [31:0] addr,
                                logic valid, logic [31:0] ins, logic [31:0] pcv, logic flt,
                                logic [31:0] fpc, logic [31:0] cnt);
        vec_t v;
        v.ready = ready; v.rvalid = rvalid; v.rdata = rdata; v.ack = ack;
        v.redir = redir; v.rpc = rpc; v.req = req; v.addr = addr; v.valid = valid;
        v.ins = ins; v.pcv = pcv; v.flt = flt; v.fpc = fpc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, vec_t v);
        chk({tag, " imem_req"}, {31'h0, bus.imem_req}, {31'h0, v.req});
        chk({tag, " instr_valid"}, {31'h0, instr_valid}, {31'h0, v.valid});
        chk({tag, " fault"}, {31'h0, fault}, {31'h0, v.flt});
        chk({tag, " fetch_count"}, fetch_count, v.cnt);
        chk({tag, " pc"}, pc, v.pcv);
        chk({tag, " pc_plus4"}, pc_plus4, v.pcv + 32'd4);
        chk({tag, " instruction"}, instruction, v.ins);
        chk({tag, " fault_pc"}, fault_pc, v.fpc);
        if (v.req || v.flt) chk({tag, " imem_addr"}, bus.imem_addr, v.addr);
    endtask

    task automatic drive(logic ready, logic rvalid, logic [31:0] rdata, logic ack,
                         logic redir, logic [31:0] rpc);
        bus.imem_ready = ready; bus.imem_rvalid = rvalid; bus.imem_rdata = rdata;
        instr_ack = ack; redirect = redir; redirect_pc = rpc;
    endtask

    initial begin
        vec_t rv;
        //            rdy rv  rdata         ack red rpc           req addr         vld ins           pc            flt fpc    cnt
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, 32'h13,       32'h100,      0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h13,       32'h100,      0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h00500093, 0, 0, 32'h0,        0, 32'h100,      0, 32'h13,       32'h100,      0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h104,      1, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h0BADF00D, 0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0BADF00D, 0, 0, 32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,      0, 32'h104,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h200,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00000297, 0, 0, 32'h0,        0, 32'h200,      0, 32'h00500093, 32'h100,      0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h204,      1, 32'h00000297, 32'h200,      0, 32'h0, 2));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h300,      0, 32'h00000297, 32'h200,      0, 32'h0, 2));
        vecs.push_back(mk(0, 1, 32'h0000006F, 0, 0, 32'h0,        0, 32'h300,      0, 32'h00000297, 32'h200,      0, 32'h0, 2));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h400,      0, 32'h304,      1, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h400,      1, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, 32'h400,      0, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(0, 1, 32'h00100073, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h0000006F, 32'h300,      0, 32'h0, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00100073, 32'hFFFFFFFC, 0, 32'h0, 4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h302,      1, 32'h0,        0, 32'h00100073, 32'hFFFFFFFC, 0, 32'h0, 4));
        vecs.push_back(mk(1, 1, 32'h22222222, 1, 1, 32'h500,      0, 32'h0,        0, 32'h00100073, 32'hFFFFFFFC, 1, 32'h302, 4));
        vecs.push_back(mk(1, 1, 32'h22222222, 1, 1, 32'h500,      0, 32'h0,        0, 32'h00100073, 32'hFFFFFFFC, 1, 32'h302, 4));

        drive(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            chk_all($sformatf("vec%0d", i), vecs[i]);
            drive(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata, vecs[i].ack, vecs[i].redir, vecs[i].rpc);
            @(negedge clk);
        end

        // Reset asserted mid-FAULT restores everything without waiting for a clock
        reset = 1'b1;
        #1;
        rv = mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h13, 32'h100, 0, 32'h0, 0);
        chk_all("reset_in_fault", rv);
        chk("reset_in_fault imem_addr", bus.imem_addr, 32'h100);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // fetch_count wrap: preload all-ones, deliver one instruction
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        @(negedge clk);
        chk("wrap req", {31'h0, bus.imem_req}, 32'h1);
        @(negedge clk);
        drive(0, 1, 32'h00A00113, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("wrap instr_valid", {31'h0, instr_valid}, 32'h1);
        chk("wrap fetch_count", fetch_count, 32'h0);
        chk("wrap instruction", instruction, 32'h00A00113);

        // Reset while WAITing; a late rvalid afterwards must not deliver anything
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rst_wait fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 32'hCAFEF00D, 0, 0, 32'h0);
        @(negedge clk);
        chk("late_rvalid instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("late_rvalid imem_req", {31'h0, bus.imem_req}, 32'h1);
        chk("late_rvalid imem_addr", bus.imem_addr, 32'h100);
        @(negedge clk);
        chk("late_rvalid2 instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("late_rvalid2 instruction", instruction, 32'h13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
